// File: rtl/mult_seq_neg.sv
// -----------------------------------------------------------------------------
// mult_seq_neg
//   Sequential limb-by-limb multiplier. It computes p = a * b, and also gives
//   the two's-complement negation of the low WIDTH_B bits of p.
//   The multiplicand is split into NUM_LIMBS = WIDTH_A/LIMB_W slices. One slice
//   is multiplied and accumulated per clock. A result is therefore ready
//   NUM_LIMBS edges after the operands are accepted.
//
// Optional feature (macro MULT_SEQ_ACC_EN):
//   This macro adds input acc_c, which is latched on accept as the initial
//   accumulator value. The result becomes p = (a*b + acc_c) mod 2^(WIDTH_A+WIDTH_B).
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   operand request
//   in_ready  out  high in IDLE; operands are accepted on in_valid && in_ready
//   a         in   WIDTH_A-bit unsigned multiplicand
//   b         in   WIDTH_B-bit unsigned multiplier
//   acc_c     in   (MULT_SEQ_ACC_EN only) initial accumulator value
//   out_valid out  high in DONE; result is held until out_ready
//   out_ready in   consumer takes the result
//   p         out  registered product (accumulator)
//   neg_b     out  -p[WIDTH_B-1:0] mod 2^WIDTH_B
// -----------------------------------------------------------------------------
module mult_seq_neg #(
  parameter int WIDTH_A = 256,
  parameter int WIDTH_B = 32,
  parameter int LIMB_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
`ifdef MULT_SEQ_ACC_EN
  input  logic [WIDTH_A+WIDTH_B-1:0] acc_c,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] p,
  output logic [WIDTH_B-1:0]         neg_b
);

  localparam int NUM_LIMBS = WIDTH_A / LIMB_W;
  localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam int WP        = WIDTH_A + WIDTH_B;
  localparam int PART_W    = LIMB_W + WIDTH_B;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LIMBS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The multiplicand must split into whole limbs.
  // Otherwise the top slice would be silently dropped.
  generate
    if (((WIDTH_A % LIMB_W) != 0) || (LIMB_W > WIDTH_A)) begin : g_badParams
      $error("mult_seq_neg: WIDTH_A must be a non-zero multiple of LIMB_W");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH_A-1:0] r_a;
  logic [WIDTH_B-1:0] r_b;
  logic [WP-1:0]      r_acc;

  logic [31:0]        w_shiftAmt;
  logic [LIMB_W-1:0]  w_limb;
  logic [PART_W-1:0]  w_partial;
  logic [WP-1:0]      w_partialShifted;
  logic [WP-1:0]      w_accInit;

  // Select the current limb and form its weighted partial product.
  // The limb is extracted with a right shift rather than an indexed part
  // select, so the bit offset can stay a plain 32-bit quantity.
  // The partial product is at most LIMB_W+WIDTH_B bits wide. When it is
  // shifted back into place, it always fits in WP bits.
  assign w_shiftAmt       = 32'(r_cnt) * 32'(LIMB_W);
  assign w_limb           = LIMB_W'(r_a >> w_shiftAmt);
  assign w_partial        = PART_W'(w_limb) * PART_W'(r_b);
  assign w_partialShifted = WP'(w_partial) << w_shiftAmt;

  // Choose the accumulator starting value that is loaded on accept.
  // The accumulate variant seeds it with acc_c. Otherwise it starts from zero.
`ifdef MULT_SEQ_ACC_EN
  assign w_accInit = acc_c;
`else
  assign w_accInit = '0;
`endif

  // Main control and datapath register block.
  // - IDLE: waits for a request and captures the operands.
  // - BUSY: folds in one limb per edge, and leaves after the last limb.
  // - DONE: holds the result until the consumer takes it.
  // Inputs are only looked at in IDLE, so operand changes during BUSY or DONE
  // have no effect. Reset wins over everything, including a pending handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= w_accInit;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= r_acc + w_partialShifted;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The handshake flags decode directly from the state.
  // The outputs come straight from the accumulator. Because of this, they keep
  // their last value through IDLE until the next accept reloads the accumulator.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign p         = r_acc;
  assign neg_b     = ~r_acc[WIDTH_B-1:0] + WIDTH_B'(1);

endmodule

// File: tb/tb_mult_seq_neg.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_neg
//   Self-checking bench for mult_seq_neg at its default parameters.
//   Expected products come from plain wide arithmetic (a*b [+ acc_c]).
//   The accumulate scenario is compiled in only when MULT_SEQ_ACC_EN is defined.
// -----------------------------------------------------------------------------
module tb_mult_seq_neg;

  localparam int WA      = 256;
  localparam int WB      = 32;
  localparam int LW      = 64;
  localparam int WP      = WA + WB;
  localparam int LATENCY = WA / LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [WP-1:0] accC;
  logic          out_valid;
  logic          out_ready;
  logic [WP-1:0] p;
  logic [WB-1:0] neg_b;

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;

  // Free-running clock, plus a cycle counter used for throughput checks.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  mult_seq_neg #(
    .WIDTH_A (WA),
    .WIDTH_B (WB),
    .LIMB_W  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MULT_SEQ_ACC_EN
    .acc_c     (accC),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .neg_b     (neg_b)
  );

  // Reference model: the full-width product plus optional addend, wrapped to WP bits.
  function automatic logic [WP-1:0] modelP(input logic [WA-1:0] ma, input logic [WB-1:0] mb,
                                           input logic [WP-1:0] mc);
    logic [WP-1:0] r;
    r = WP'(ma) * WP'(mb);
    r = r + mc;
    return r;
  endfunction

  // Reference model: arithmetic negation of the low word, modulo 2^WB.
  function automatic logic [WB-1:0] modelNeg(input logic [WP-1:0] pv);
    logic [WB-1:0] low;
    low = pv[WB-1:0];
    return WB'(0) - low;
  endfunction

  function automatic logic [WA-1:0] randA();
    logic [WA-1:0] r;
    r = '0;
    for (int k = 0; k < WA / 32; k++) begin
      r = {r[WA-33:0], 32'($urandom)};
    end
    return r;
  endfunction

  // Present one request for a single edge.
  // Called at #1 after an edge while the DUT is idle.
  task automatic applyStimulus(input logic [WA-1:0] ta, input logic [WB-1:0] tb,
                               input logic [WP-1:0] tc);
    a        = ta;
    b        = tb;
    accC     = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid appears, with a bound of 20 edges.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    accC      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 256'd7;
    b         = 32'd9;
    accC      = '0;
    @(posedge clk);
    #1;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passCount++;
    checkCount++; if (p !== '0) $display("[TB] FAIL reset_p: got %h expected 0", p); else passCount++;
    checkCount++; if (neg_b !== '0) $display("[TB] FAIL reset_neg_b: got %h expected 0", neg_b); else passCount++;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    applyStimulus(256'd1, 32'd1, '0);
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL basic_busy_in_ready: got %b expected 0", in_ready); else passCount++;
    waitResult(lat);
    checkCount++; if (lat != LATENCY) $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LATENCY); else passCount++;
    checkCount++; if (p !== WP'(1)) $display("[TB] FAIL basic_p: got %h expected 1", p); else passCount++;
    checkCount++; if (neg_b !== 32'hFFFFFFFF) $display("[TB] FAIL basic_neg_b: got %h expected ffffffff", neg_b); else passCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_extremes();
    int            lat;
    logic [WA-1:0] aMax;
    logic [WP-1:0] expP;
    aMax = '1;
    expP = modelP(aMax, 32'hFFFFFFFF, '0);
    applyStimulus(aMax, 32'hFFFFFFFF, '0);
    waitResult(lat);
    checkCount++; if (p !== expP) $display("[TB] FAIL max_p: got %h expected %h", p, expP); else passCount++;
    checkCount++; if (neg_b !== 32'hFFFFFFFF) $display("[TB] FAIL max_neg_b: got %h expected ffffffff", neg_b); else passCount++;
    @(posedge clk);
    #1;
    applyStimulus(aMax, 32'd0, '0);
    waitResult(lat);
    checkCount++; if (p !== '0) $display("[TB] FAIL bzero_p: got %h expected 0", p); else passCount++;
    checkCount++; if (neg_b !== '0) $display("[TB] FAIL bzero_neg_b: got %h expected 0", neg_b); else passCount++;
    @(posedge clk);
    #1;
    // The product is non-zero, but its low word is zero.
    expP = modelP(WA'(1) << 32, 32'd3, '0);
    applyStimulus(WA'(1) << 32, 32'd3, '0);
    waitResult(lat);
    checkCount++; if (p !== expP) $display("[TB] FAIL lowzero_p: got %h expected %h", p, expP); else passCount++;
    checkCount++; if (neg_b !== '0) $display("[TB] FAIL lowzero_neg_b: got %h expected 0", neg_b); else passCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int            lat;
    logic [WA-1:0] ta;
    logic [WB-1:0] tb;
    logic [WP-1:0] expP;
    logic [WB-1:0] expN;
    ta        = randA();
    tb        = 32'($urandom);
    expP      = modelP(ta, tb, '0);
    expN      = modelNeg(expP);
    out_ready = 1'b0;
    applyStimulus(ta, tb, '0);
    waitResult(lat);
    checkCount++; if (lat != LATENCY) $display("[TB] FAIL stall_latency: got %0d expected %0d", lat, LATENCY); else passCount++;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a        = ~a;
      b        = ~b;
      @(posedge clk);
      #1;
      checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_out_valid: got %b expected 1", out_valid); else passCount++;
      checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); else passCount++;
      checkCount++; if (p !== expP) $display("[TB] FAIL stall_p: got %h expected %h", p, expP); else passCount++;
      checkCount++; if (neg_b !== expN) $display("[TB] FAIL stall_neg_b: got %h expected %h", neg_b, expN); else passCount++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL release_out_valid: got %b expected 0", out_valid); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); else passCount++;
    checkCount++; if (p !== expP) $display("[TB] FAIL idle_hold_p: got %h expected %h", p, expP); else passCount++;
    checkCount++; if (neg_b !== expN) $display("[TB] FAIL idle_hold_neg_b: got %h expected %h", neg_b, expN); else passCount++;
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    applyStimulus(256'd7, 32'd9, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); else passCount++;
    checkCount++; if (p !== '0) $display("[TB] FAIL midrst_p: got %h expected 0", p); else passCount++;
    checkCount++; if (neg_b !== '0) $display("[TB] FAIL midrst_neg_b: got %h expected 0", neg_b); else passCount++;
    applyStimulus(256'd3, 32'd5, '0);
    waitResult(lat);
    checkCount++; if (lat != LATENCY) $display("[TB] FAIL after_rst_latency: got %0d expected %0d", lat, LATENCY); else passCount++;
    checkCount++; if (p !== WP'(15)) $display("[TB] FAIL after_rst_p: got %h expected f", p); else passCount++;
    checkCount++; if (neg_b !== 32'hFFFFFFF1) $display("[TB] FAIL after_rst_neg_b: got %h expected fffffff1", neg_b); else passCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int            lat;
    int            lastCycle;
    logic [WA-1:0] ta;
    logic [WB-1:0] tb;
    logic [WP-1:0] expP;
    logic [WB-1:0] expN;
    lastCycle = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ta   = randA();
      tb   = (i % 97 == 5) ? 32'd0 : 32'($urandom);
      a    = ta;
      b    = tb;
      expP = modelP(ta, tb, '0);
      expN = modelNeg(expP);
      waitResult(lat);
      checkCount++; if (p !== expP) $display("[TB] FAIL b2b_p[%0d]: got %h expected %h", i, p, expP); else passCount++;
      checkCount++; if (neg_b !== expN) $display("[TB] FAIL b2b_neg_b[%0d]: got %h expected %h", i, neg_b, expN); else passCount++;
      if (i > 0) begin
        checkCount++; if (cycleCount - lastCycle != 6) $display("[TB] FAIL b2b_period[%0d]: got %0d expected 6", i, cycleCount - lastCycle); else passCount++;
      end
      lastCycle = cycleCount;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

`ifdef MULT_SEQ_ACC_EN
  task automatic test_accumulate();
    int            lat;
    logic [WP-1:0] cMax;
    applyStimulus(256'd2, 32'd3, WP'(5));
    waitResult(lat);
    checkCount++; if (p !== WP'(11)) $display("[TB] FAIL acc_p: got %h expected b", p); else passCount++;
    checkCount++; if (neg_b !== 32'hFFFFFFF5) $display("[TB] FAIL acc_neg_b: got %h expected fffffff5", neg_b); else passCount++;
    @(posedge clk);
    #1;
    cMax = '1;
    applyStimulus(256'd1, 32'd1, cMax);
    waitResult(lat);
    checkCount++; if (p !== '0) $display("[TB] FAIL acc_wrap_p: got %h expected 0", p); else passCount++;
    checkCount++; if (neg_b !== '0) $display("[TB] FAIL acc_wrap_neg_b: got %h expected 0", neg_b); else passCount++;
    @(posedge clk);
    #1;
    accC = '0;
  endtask
`endif

  // Global time limit, so that a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Run every scenario in sequence, then print the summary.
  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_reset_mid_busy();
    resetDut();
    test_back_to_back();
    resetDut();
`ifdef MULT_SEQ_ACC_EN
    test_accumulate();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
